dmem_resp: RTL and testbench

- Data-memory responder at the far end of the execute-stage load/store interface.
- Accepts a word address, a write strobe and store data from the LD/ST unit.
- Stores are performed in the accept cycle. Loads return read data after a fixed latency.
- Holds off new requests with busy_o while a load is in flight.

---
 rtl/dmem_resp_pkg.sv | 21 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_resp.sv | 145 ++++++++++++++
 tb/tb_dmem_resp.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared definitions for the data-memory responder: execute-stage widths,
// store opcode, responder state encoding and wait-counter width.
package dmem_resp_pkg;

    // Widths shared with the execute stage LD/ST unit.
    localparam int ADDR_DEF  = 16;
    localparam int W_OPR_DEF = 32;

    // Store opcode as decoded upstream; the responder only sees write_i.
    localparam logic [6:0] OP_STORE = 7'b001_1001;

    // Wait counter width; covers RD_LAT up to 15.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : dmem_resp_pkg

// File: rtl/dmem_array.sv
// DEPTH x W word array: synchronous write, registered read, no reset.
// Write and read share one address because only one request exists per cycle.
module dmem_array #(
    parameter int DEPTH = 1024,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Write on store accept; capture the addressed word on load accept.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/dmem_resp.sv
// Data-memory responder for the execute-stage load/store interface.
// Stores complete in the accept cycle; loads respond RD_LAT cycles later.
// Optional build macro DMEM_BOUNDS_CHECK_EN adds err_o and out-of-range
// detection for addresses >= DEPTH (otherwise addresses alias modulo DEPTH).
module dmem_resp
    import dmem_resp_pkg::*;
#(
    parameter int ADDR   = ADDR_DEF,
    parameter int W_OPR  = W_OPR_DEF,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_v_i,
    input  logic [ADDR-1:0]  addr_i,
    input  logic             write_i,
    input  logic [W_OPR-1:0] wdata_i,
    output logic             busy_o,
    output logic             rdata_v_o,
    output logic [W_OPR-1:0] rdata_o
`ifdef DMEM_BOUNDS_CHECK_EN
    ,
    output logic             err_o
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W_OPR-1:0]   rdata_q;
    logic [W_OPR-1:0]   arr_rdata;
    logic [W_OPR-1:0]   resp_data;
    logic [AW-1:0]      idx;
    logic               accept, st_acc, ld_acc;
    logic               oob;

    assign idx    = addr_i[AW-1:0];
    assign busy_o = (state_q == WAIT);
    assign accept = req_v_i & ~busy_o;
    assign st_acc = accept &  write_i;
    assign ld_acc = accept & ~write_i;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [ADDR:0] DEPTH_X = (ADDR+1)'(DEPTH);

    logic oob_ld_q;
    logic err_st_q;

    assign oob = ({1'b0, addr_i} >= DEPTH_X);

    // Remember whether the in-flight load was out of range, and flag
    // out-of-range stores for the cycle after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_ld_q <= 1'b0;
            err_st_q <= 1'b0;
        end else begin
            if (ld_acc) begin
                oob_ld_q <= oob;
            end
            err_st_q <= st_acc & oob;
        end
    end

    assign resp_data = oob_ld_q ? '0 : arr_rdata;
    assign err_o     = err_st_q | (rdata_v_o & oob_ld_q);
`else
    assign oob       = 1'b0;
    assign resp_data = arr_rdata;
`endif

    dmem_array #(
        .DEPTH (DEPTH),
        .W     (W_OPR),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .addr_i  (idx),
        .we_i    (st_acc & ~oob),
        .wdata_i (wdata_i),
        .re_i    (ld_acc),
        .rdata_o (arr_rdata)
    );

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a load accepted in IDLE or RESP starts a new latency
    // window; RESP with no load falls back to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (ld_acc) begin
                    if (RD_LAT == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(RD_LAT - 2);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign rdata_v_o = (state_q == RESP);

    // Read data is driven live during the response cycle and held afterwards,
    // so a reset (which forces IDLE) shows the cleared hold register at once.
    assign rdata_o = rdata_v_o ? resp_data : rdata_q;

    // Hold register for rdata_o between response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_o;
        end
    end

endmodule : dmem_resp

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: three instances (RD_LAT 2, 3, 1) share
// one request stream and are compared every cycle against a transaction-level
// model (memory array, pending-load record with its due cycle, held data).
module tb_dmem_resp;

    localparam int ADDR  = 16;
    localparam int W     = 32;
    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_v;
    logic             write;
    logic [ADDR-1:0]  addr;
    logic [W-1:0]     wdata;
    logic [NDUT-1:0]  busy;
    logic [NDUT-1:0]  vld;
    logic [NDUT-1:0]  err;
    logic [W-1:0]     rdata [NDUT];

    always #5 clk = ~clk;

    dmem_resp #(.ADDR(ADDR), .W_OPR(W), .DEPTH(DEPTH), .RD_LAT(2)) u0 (
        .clk(clk), .rst_n(rst_n), .req_v_i(req_v), .addr_i(addr),
        .write_i(write), .wdata_i(wdata), .busy_o(busy[0]),
        .rdata_v_o(vld[0]), .rdata_o(rdata[0])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err_o(err[0])
`endif
    );

    dmem_resp #(.ADDR(ADDR), .W_OPR(W), .DEPTH(DEPTH), .RD_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .req_v_i(req_v), .addr_i(addr),
        .write_i(write), .wdata_i(wdata), .busy_o(busy[1]),
        .rdata_v_o(vld[1]), .rdata_o(rdata[1])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err_o(err[1])
`endif
    );

    dmem_resp #(.ADDR(ADDR), .W_OPR(W), .DEPTH(DEPTH), .RD_LAT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .req_v_i(req_v), .addr_i(addr),
        .write_i(write), .wdata_i(wdata), .busy_o(busy[2]),
        .rdata_v_o(vld[2]), .rdata_o(rdata[2])
`ifdef DMEM_BOUNDS_CHECK_EN
        , .err_o(err[2])
`endif
    );

`ifndef DMEM_BOUNDS_CHECK_EN
    assign err = '0;
`endif

    // ---------------- reference model ----------------
    logic [W-1:0] mem_m      [NDUT][DEPTH];
    bit           known_m    [NDUT][DEPTH];
    bit           pend       [NDUT];
    int           due        [NDUT];
    logic [W-1:0] pend_data  [NDUT];
    bit           pend_known [NDUT];
    bit           pend_err   [NDUT];
    logic [W-1:0] last_m     [NDUT];
    bit           last_known [NDUT];
    bit           err_st     [NDUT];
    int           cyc;

    int  checks = 0;
    int  errors = 0;
    bit  busy2_seen = 1'b0;
    int  pulse1_q [$];

    function automatic int lat(input int k);
        case (k)
            0:       return 2;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit oob_f(input logic [ADDR-1:0] a);
`ifdef DMEM_BOUNDS_CHECK_EN
        return int'(a) >= DEPTH;
`else
        return (a == '1) && (a != a);  // never out of range without the check
`endif
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            pend[k]       = 1'b0;
            last_m[k]     = '0;
            last_known[k] = 1'b1;
            err_st[k]     = 1'b0;
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < NDUT; k++) begin
            bit           eb, ev, kn;
            logic [W-1:0] er;
            eb = pend[k] && (cyc < due[k]);
            ev = pend[k] && (cyc == due[k]);
            er = ev ? pend_data[k]  : last_m[k];
            kn = ev ? pend_known[k] : last_known[k];
            chk($sformatf("busy[%0d]", k), W'(busy[k]), W'(eb));
            chk($sformatf("rdata_v[%0d]", k), W'(vld[k]), W'(ev));
            if (kn) chk($sformatf("rdata[%0d]", k), rdata[k], er);
`ifdef DMEM_BOUNDS_CHECK_EN
            chk($sformatf("err[%0d]", k), W'(err[k]), W'(err_st[k] | (ev & pend_err[k])));
`endif
        end
        if (busy[2]) busy2_seen = 1'b1;
        if (vld[1])  pulse1_q.push_back(cyc);
    endtask

    task automatic update_model();
        for (int k = 0; k < NDUT; k++) begin
            bit acc;
            int ix;
            acc = req_v && !(pend[k] && (cyc < due[k]));
            ix  = int'(addr) % DEPTH;
            if (pend[k] && (cyc == due[k])) begin
                last_m[k]     = pend_data[k];
                last_known[k] = pend_known[k];
                pend[k]       = 1'b0;
            end
            err_st[k] = 1'b0;
            if (acc && write) begin
                if (oob_f(addr)) begin
                    err_st[k] = 1'b1;
                end else begin
                    mem_m[k][ix]   = wdata;
                    known_m[k][ix] = 1'b1;
                end
            end
            if (acc && !write) begin
                pend[k]       = 1'b1;
                due[k]        = cyc + lat(k);
                pend_err[k]   = oob_f(addr);
                pend_data[k]  = oob_f(addr) ? '0 : mem_m[k][ix];
                pend_known[k] = oob_f(addr) ? 1'b1 : known_m[k][ix];
            end
        end
        cyc++;
    endtask

    task automatic drive(input bit r, input bit w, input logic [ADDR-1:0] a, input logic [W-1:0] d);
        req_v = r; write = w; addr = a; wdata = d;
    endtask

    task automatic end_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        end_cycle();
    endtask

    // ---------------- directed table (expectations for RD_LAT=2) ----------------
    typedef struct {
        bit              req;
        bit              wr;
        logic [ADDR-1:0] a;
        logic [W-1:0]    d;
        bit              eb;
        bit              ev;
        logic [W-1:0]    er;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{1, 1, 16'h0010, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[1]  = '{1, 0, 16'h0010, 32'h0,        0, 0, 32'h0};
        tbl[2]  = '{0, 0, 16'h0000, 32'h0,        1, 0, 32'h0};
        tbl[3]  = '{0, 0, 16'h0000, 32'h0,        0, 1, 32'hDEADBEEF};
        tbl[4]  = '{1, 1, 16'h0001, 32'hA1A1A1A1, 0, 0, 32'hDEADBEEF};
        tbl[5]  = '{1, 1, 16'h0002, 32'hA2A2A2A2, 0, 0, 32'hDEADBEEF};
        tbl[6]  = '{1, 1, 16'h0003, 32'hA3A3A3A3, 0, 0, 32'hDEADBEEF};
        tbl[7]  = '{1, 1, 16'h0004, 32'hA4A4A4A4, 0, 0, 32'hDEADBEEF};
        tbl[8]  = '{1, 0, 16'h0001, 32'h0,        0, 0, 32'hDEADBEEF};
        tbl[9]  = '{1, 0, 16'h0002, 32'h0,        1, 0, 32'hDEADBEEF};
        tbl[10] = '{1, 0, 16'h0002, 32'h0,        0, 1, 32'hA1A1A1A1};
        tbl[11] = '{1, 0, 16'h0003, 32'h0,        1, 0, 32'hA1A1A1A1};
        tbl[12] = '{1, 0, 16'h0003, 32'h0,        0, 1, 32'hA2A2A2A2};
        tbl[13] = '{1, 0, 16'h0004, 32'h0,        1, 0, 32'hA2A2A2A2};
        tbl[14] = '{1, 0, 16'h0004, 32'h0,        0, 1, 32'hA3A3A3A3};
        tbl[15] = '{0, 0, 16'h0000, 32'h0,        1, 0, 32'hA3A3A3A3};
        tbl[16] = '{0, 0, 16'h0000, 32'h0,        0, 1, 32'hA4A4A4A4};
        tbl[17] = '{0, 0, 16'h0000, 32'h0,        0, 0, 32'hA4A4A4A4};

        cyc = 0;
        model_reset();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < DEPTH; i++) known_m[k][i] = 1'b0;

        // Reset state.
        drive(0, 0, '0, '0);
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("rst_busy[%0d]", k),  W'(busy[k]), 32'h0);
            chk($sformatf("rst_vld[%0d]", k),   W'(vld[k]),  32'h0);
            chk($sformatf("rst_rdata[%0d]", k), rdata[k],    32'h0);
            chk($sformatf("rst_err[%0d]", k),   W'(err[k]),  32'h0);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // Table: store/load basics and back-to-back stores.
        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].req, tbl[i].wr, tbl[i].a, tbl[i].d);
            @(negedge clk);
            chk($sformatf("tbl%0d_busy", i),  W'(busy[0]), W'(tbl[i].eb));
            chk($sformatf("tbl%0d_vld", i),   W'(vld[0]),  W'(tbl[i].ev));
            chk($sformatf("tbl%0d_rdata", i), rdata[0],    tbl[i].er);
            check_outputs();
            end_cycle();
        end

        // RD_LAT=3: a load held for four cycles behind an in-flight load.
        pulse1_q.delete();
        drive(1, 0, 16'h0010, '0);
        cycle();
        drive(1, 0, 16'h0001, '0);
        repeat (4) cycle();
        drive(0, 0, '0, '0);
        repeat (6) cycle();
        chk("lat3_pulse_count", W'(pulse1_q.size()), 32'd2);
        if (pulse1_q.size() == 2)
            chk("lat3_pulse_gap", W'(pulse1_q[1] - pulse1_q[0]), 32'd3);

        // Reset while loads are waiting.
        drive(1, 1, 16'h0005, 32'h12345678);
        cycle();
        drive(1, 0, 16'h0005, '0);
        cycle();
        drive(0, 0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wait_rst_busy[%0d]", k),  W'(busy[k]), 32'h0);
            chk($sformatf("wait_rst_vld[%0d]", k),   W'(vld[k]),  32'h0);
            chk($sformatf("wait_rst_rdata[%0d]", k), rdata[k],    32'h0);
        end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) cycle();
        drive(1, 0, 16'h0005, '0);
        cycle();
        drive(0, 0, '0, '0);
        repeat (4) cycle();
        chk("rst_mem_kept", rdata[0], 32'h12345678);

        // Address 0x0400: aliases to 0 or is rejected by the bounds check.
        drive(1, 1, 16'h0000, 32'hCAFE0000);
        cycle();
        drive(1, 1, 16'h0400, 32'hBAD00400);
        cycle();
        drive(0, 0, '0, '0);
        @(negedge clk);
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oob_store_err", W'(err), 32'h7);
`else
        chk("alias_no_err", W'(err), 32'h0);
`endif
        check_outputs();
        end_cycle();
        drive(1, 0, 16'h0000, '0);
        cycle();
        drive(0, 0, '0, '0);
        repeat (4) cycle();
`ifdef DMEM_BOUNDS_CHECK_EN
        chk("oob_mem_unchanged", rdata[0], 32'hCAFE0000);
        drive(1, 0, 16'h0400, '0);
        cycle();
        drive(0, 0, '0, '0);
        cycle();
        @(negedge clk);
        chk("oob_load_data", rdata[0], 32'h0);
        chk("oob_load_err", W'(err[0]), 32'h1);
        check_outputs();
        end_cycle();
        repeat (3) cycle();
`else
        chk("alias_0400", rdata[0], 32'hBAD00400);
`endif

        // Prefill the random address window, then random traffic.
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, ADDR'(i), $urandom);
            cycle();
        end
        drive(0, 0, '0, '0);
        repeat (4) cycle();
        for (int i = 0; i < 500; i++) begin
            logic [ADDR-1:0] a;
            a = ADDR'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a = a | 16'h0400;
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4, a, $urandom);
            cycle();
        end
        drive(0, 0, '0, '0);
        repeat (5) cycle();

        chk("lat1_never_busy", W'(busy2_seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dmem_resp
